data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the single-port word-wide data memory (synchronous 1-cycle read, full-word write only, no byte enables).
- Accepts byte-addressed byte/half/word loads and stores. Performs lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores.
- Flags misaligned or invalid-size requests without touching memory.

Parameters:
- ADDR_WIDTH, 16, word-address width of the data memory; byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, memory word width; only 32 is supported, so elaboration fails otherwise.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=invalid
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; 0 for stores/errors
- rsp_err  out  1  misaligned/invalid request, qualified by rsp_valid
- mem_rd  out  1  memory read strobe
- mem_wd  out  1  memory write strobe
- mem_size  out  2  captured req_size, forwarded
- mem_addr  out  ADDR_WIDTH  word address = captured req_addr[ADDR_WIDTH+1:2]
- mem_data_in  out  32  word written to memory
- mem_data_out  in  32  memory read data, valid the cycle after mem_rd

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_rd=0; mem_wd=0; mem_addr=0; mem_data_in=0; mem_size=0.
- Accept: on req_valid && req_ready, capture we, size, unsigned, addr and wdata into registers. Later request-input changes are ignored until IDLE.
- Error check at accept:
  - size==3 is an error.
  - size==1 with addr[0]!=0 is misaligned.
  - size==2 with addr[1:0]!=0 is misaligned.
  - On error go to ERR; no memory strobe is issued.
- States: IDLE, READ, EXTRACT, MERGE, WRITE, ERR, RESP.
- Transitions from IDLE on accept:
  - Word store -> WRITE.
  - Load or sub-word store -> READ.
  - Error -> ERR.
- Transitions from other states:
  - READ: mem_rd=1. Next EXTRACT for a load, MERGE for a store.
  - EXTRACT: register the extended lane into rsp_rdata -> RESP.
  - MERGE: register the merged word into the write-data register -> WRITE.
  - WRITE: mem_wd=1 with mem_data_in -> RESP.
  - ERR: set rsp_err, rsp_rdata=0 -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. There is no response backpressure.
- Strobes: mem_rd and mem_wd are decoded from state and never high simultaneously. mem_addr and mem_size are stable from READ/WRITE entry through leaving the state.
- Latency (accept edge = cycle 0, rsp_valid cycle):
  - Error: 2.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
  - Throughput: one request per latency+1 cycles.
- Lanes are little-endian:
  - Byte lane = addr[1:0], i.e. bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Half lane = addr[1], i.e. bits [16*addr[1]+15 : 16*addr[1]].
  - Word = full 32 bits.
- Load extension: sign-extend from bit 7/15 unless unsigned. Word loads ignore req_unsigned.
- Merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]. All other bytes come from mem_data_out unchanged.
- rsp_rdata and rsp_err hold their value until the next RESP. Stores load rsp_rdata=0, rsp_err=0.
- Reset mid-operation: immediate return to IDLE with all strobes deasserted. A sub-word store aborted before WRITE leaves memory unchanged. No response is ever emitted for an aborted request.

Decomposition:
- Package data_mem_pkg:
  - Size encodings SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2.
  - State encoding constants.
  - Misalignment check function.
- Sub-module mem_lane_align (purely combinational):
  - Inputs: size, addr[1:0], unsigned, rdata, wdata.
  - Outputs: extracted load value and merged store word.
  - Instantiated once; data_mem_ctrl holds the FSM and all registers.

Test Plan:
- Word store then load: store addr 0x0010 wdata 0xDEADBEEF, then load word 0x0010.
  - Store: rsp_valid at cycle 2, mem_wd one cycle, mem_addr=0x0004.
  - Load: rsp_rdata=0xDEADBEEF at cycle 3.
- Sub-word store: memory word 0x0004 = 0x11223344; store byte addr 0x0012 wdata 0x000000AB.
  - Exactly one mem_rd, then one mem_wd with mem_data_in=0x11AB3344.
  - rsp_valid at cycle 4.
- Load extension: on word 0x80FF7F01:
  - Byte load addr 1 signed -> 0x0000007F.
  - Byte load addr 2 signed -> 0xFFFFFFFF.
  - Half load addr 2 signed -> 0xFFFF80FF.
  - Half load addr 2 unsigned -> 0x000080FF.
- Errors:
  - Half at addr 0x0003 -> rsp_err=1, rsp_rdata=0, rsp_valid at cycle 2.
  - Word at 0x0002 -> rsp_err=1, rsp_rdata=0, rsp_valid at cycle 2.
  - size=3 -> rsp_err=1, rsp_rdata=0, rsp_valid at cycle 2.
  - In all three cases mem_rd and mem_wd stay 0.
- Handshake: hold req_valid high with back-to-back requests.
  - req_ready low from accept until the cycle after rsp_valid.
  - Second request is captured only in IDLE, and its inputs are changed mid-op without effect.
- Reset abort: assert rst_n=0 during MERGE of a half store.
  - Outputs return to reset values asynchronously.
  - Memory word is unchanged; no rsp_valid is emitted.
  - Next request completes normally.

Source files
------------

// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data memory load/store sequencer:
//   - request size encodings as they appear on req_size / mem_size
//   - FSM state type used by data_mem_ctrl
//   - alignment/validity check applied when a request is accepted
// ---------------------------------------------------------------------------
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_EXTRACT = 3'd2,
        ST_MERGE   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_ERR     = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

    // A request is rejected when its size code is invalid or when its byte
    // address is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane logic for a little-endian 32-bit word.
// Ports:
//   size          access size code (byte/half/word)
//   addr          low two bits of the byte address
//   load_unsigned 1 = zero-extend loads, 0 = sign-extend
//   rdata         word read from memory
//   wdata         right-justified store data
//   load_data     addressed lane of rdata, extended to 32 bits
//   store_data    rdata with the addressed lane replaced by wdata
// ---------------------------------------------------------------------------
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        load_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the lane for loads and splice the store data into the read word.
    // Byte lanes start at bit 8*addr, half lanes at bit 16*addr[1].
    always_comb begin
        byte_lane  = rdata[{addr, 3'b000} +: 8];
        half_lane  = rdata[{addr[1], 4'b0000} +: 16];
        load_data  = '0;
        store_data = rdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
                store_data[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{~load_unsigned & half_lane[15]}}, half_lane};
                store_data[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SIZE_WORD: begin
                load_data  = rdata;
                store_data = wdata;
            end
            default: begin
                load_data  = '0;
                store_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Load/store sequencer between the core memory stage and a single-port,
// word-wide data memory with 1-cycle synchronous read and full-word writes.
// Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned     store flag, size code, zero-extend
//   req_addr, req_wdata                byte address, right-justified data
//   rsp_valid, rsp_rdata, rsp_err      one-cycle completion, load data, error
//   mem_rd, mem_wd                     memory read / write strobes
//   mem_size, mem_addr, mem_data_in    captured size, word address, write word
//   mem_data_out                       memory read data (cycle after mem_rd)
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_rd,
    output logic                  mem_wd,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("data_mem_ctrl supports only DATA_WIDTH == 32");
    end

    state_t state;
    state_t next_state;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  accept;
    logic [31:0]           load_data;
    logic [31:0]           store_data;

    assign accept      = req_valid && (state == ST_IDLE);
    assign mem_addr    = addr_q[ADDR_WIDTH+1:2];
    assign mem_size    = size_q;
    assign mem_data_in = wdata_q;

    mem_lane_align u_lane_align (
        .size          (size_q),
        .addr          (addr_q[1:0]),
        .load_unsigned (unsigned_q),
        .rdata         (mem_data_out),
        .wdata         (wdata_q),
        .load_data     (load_data),
        .store_data    (store_data)
    );

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode. Full-word stores need no read, so they
    // skip straight to WRITE; errors never touch the memory.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wd     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        next_state = ST_ERR;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        next_state = ST_WRITE;
                    end else begin
                        next_state = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_rd     = 1'b1;
                next_state = we_q ? ST_MERGE : ST_EXTRACT;
            end
            ST_EXTRACT: next_state = ST_RESP;
            ST_MERGE:   next_state = ST_WRITE;
            ST_WRITE: begin
                mem_wd     = 1'b1;
                next_state = ST_RESP;
            end
            ST_ERR:     next_state = ST_RESP;
            ST_RESP: begin
                rsp_valid  = 1'b1;
                next_state = ST_IDLE;
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    // Request capture and datapath registers. wdata_q doubles as the
    // memory write register: it holds the store data for word stores and
    // is overwritten with the merged word for sub-word stores. The response
    // registers are loaded one state before RESP and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                    end
                end
                ST_EXTRACT: begin
                    rsp_rdata <= load_data;
                    rsp_err   <= 1'b0;
                end
                ST_MERGE: begin
                    wdata_q <= store_data;
                end
                ST_WRITE: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                ST_ERR: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
